alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Execute stage directly downstream of ALU_Control. Consumes the eight decoded control lines (AC0..AC7) and the AluActive qualifier, registers them with the two 8-bit operands, and performs one add-based ALU operation per active cycle. The 8-bit result lands in a result register and C/Z/N/V lands in a flags register, both visible to the pipeline and the flags bus. Two-stage pipeline: operand/control capture, then compute/writeback.

## Interface
- DATA_W, 8, operand/result width
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- AluActive  in  1  current opcode is an ALU op; qualifies capture into S1
- AC0_RHS0..AC3_RHS3  in  1 each  rhs_sel[3:0]
- AC4_LHS0, AC5_LHS1  in  1 each  lhs_sel[1:0]
- AC6_CS0, AC7_CS1  in  1 each  cin_sel[1:0]
- OpA, OpB  in  DATA_W each  operands, sampled with AluActive
- Stall  in  1  freeze both stages
- FlagLoad  in  1  load flags register from FlagIn
- FlagIn  in  4  {V,N,Z,C} restore value
- AluResult  out  DATA_W  result register
- ResultValid  out  1  one-cycle pulse after result register loads
- Flags  out  4  {V,N,Z,C} flags register
- IllegalOp  out  1  sticky; set when a reserved rhs_sel reaches S2

## Operation
- S1 (capture): on edge with Stall=0, s1_valid<=AluActive; if AluActive, latch OpA, OpB, rhs_sel, lhs_sel, cin_sel.
- S2 (compute/writeback): on edge with Stall=0 and s1_valid=1, AluResult<=sum[7:0], flags updated, ResultValid<=1; otherwise ResultValid<=0.
- LHS: 0 A, 1 0x00, 2 ~A, 3 A.
- RHS: 0 B, 1 ~B, 2 0x00, 3 0xFF, 4 A&B, 5 A|B, 6 A^B, 7 {1'b0,B[7:1]}, 8-15 reserved -> 0x00 and set IllegalOp.
- cin: 0 zero, 1 one, 2 Flags.C, 3 ~Flags.C; Flags.C read from flags register at compute time.
- sum = LHS + RHS + cin, 9 bits. C=sum[8]; Z=(sum[7:0]==0); N=sum[7]; V=(LHS[7]==RHS[7])&&(sum[7]!=LHS[7]).
- Logic ops (RHS 4-6) with LHS=0x00, cin=0 give pure logic results; C=0, V=0 by arithmetic.
- FlagLoad: Flags<=FlagIn on the same edge regardless of Stall; wins over a simultaneous S2 flag update (result still written).
- IllegalOp cleared only by Reset.

## Timing
- Reset: s1_valid=0, S1 regs 0, AluResult=0x00, Flags=0x0, ResultValid=0, IllegalOp=0.
- Latency: AluActive sampled at edge k -> AluResult/Flags valid after edge k+1; ResultValid high cycle after k+1.
- Throughput one op/cycle; back-to-back carry chaining needs no bypass: op k+1 computes after op k's flags are written.
- Stall=1: S1, S2 and result hold; ResultValid=0; inputs ignored; on release S1 content advances next edge.
- Reset mid-operation drops any S1 op; no ResultValid follows.
- Add wraps modulo 2^DATA_W; overflow only visible in C/V.

## Configuration
- ALU_EXEC_PARITY_EN: defined -> Flags widens to 5 bits {P,V,N,Z,C}, P = even parity of result (1 when XOR of bits is 0), FlagIn widens to 5; undefined -> 4-bit flags, no parity logic.

## Structure
- Package alu_exec_pkg: rhs_sel/lhs_sel/cin_sel encodings as localparams, flag bit indices, FLAG_W derived from the macro.
- One sub-module alu_exec_core: purely combinational LHS/RHS/cin muxing, adder and flag generation; stage registers stay in alu_exec_stage.

## Test plan
- Reset, then ADD: A=0x7F, B=0x01, sel 0/0/0 -> AluResult=0x80, C=0 Z=0 N=1 V=1, ResultValid one cycle, 2 edges after capture.
- SUB: A=0x05, B=0x05, LHS A, RHS ~B, cin 1 -> 0x00, Z=1, C=1.
- Carry chain: 0xFF+0x01 (cin 0) then 0x00+0x00 (cin_sel 2) back-to-back -> 0x00 C=1, then 0x01 C=0.
- Stall 3 cycles with op in S1 -> AluResult unchanged, ResultValid low; result appears first edge after release.
- FlagLoad=1 FlagIn=0xA same edge as S2 write -> Flags=0xA, AluResult updated.
- rhs_sel=9 -> AluResult=A, IllegalOp=1 sticky until Reset.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared encodings and widths for the ALU execute stage.
// Defining ALU_EXEC_PARITY_EN adds a parity flag, widening the flags register to 5 bits.
package alu_exec_pkg;

   localparam int DATA_W = 8;

`ifdef ALU_EXEC_PARITY_EN
   localparam int FLAG_W = 5;
   localparam int FLAG_P = 4;
`else
   localparam int FLAG_W = 4;
`endif

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   localparam logic [1:0] LHS_A     = 2'd0;
   localparam logic [1:0] LHS_ZERO  = 2'd1;
   localparam logic [1:0] LHS_NOT_A = 2'd2;
   localparam logic [1:0] LHS_A_ALT = 2'd3;

   localparam logic [3:0] RHS_B     = 4'd0;
   localparam logic [3:0] RHS_NOT_B = 4'd1;
   localparam logic [3:0] RHS_ZERO  = 4'd2;
   localparam logic [3:0] RHS_ONES  = 4'd3;
   localparam logic [3:0] RHS_AND   = 4'd4;
   localparam logic [3:0] RHS_OR    = 4'd5;
   localparam logic [3:0] RHS_XOR   = 4'd6;
   localparam logic [3:0] RHS_SHR   = 4'd7;

   localparam logic [1:0] CIN_ZERO  = 2'd0;
   localparam logic [1:0] CIN_ONE   = 2'd1;
   localparam logic [1:0] CIN_C     = 2'd2;
   localparam logic [1:0] CIN_NOT_C = 2'd3;

endpackage

// File: rtl/alu_exec_core.sv
// Combinational operand muxing, adder and flag generation for the execute stage.
// Parity flag generated only when ALU_EXEC_PARITY_EN is defined.
module alu_exec_core
   import alu_exec_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        rhs_sel,
   input  logic [1:0]        lhs_sel,
   input  logic [1:0]        cin_sel,
   input  logic              carry_flag,
   output logic [DATA_W-1:0] result,
   output logic [FLAG_W-1:0] flags_next,
   output logic              illegal
);

   logic [DATA_W-1:0] lhs;
   logic [DATA_W-1:0] rhs;
   logic              cin;
   logic [DATA_W:0]   sum;

   always_comb begin
      lhs = a;
      case (lhs_sel)
         LHS_A:     lhs = a;
         LHS_ZERO:  lhs = '0;
         LHS_NOT_A: lhs = ~a;
         LHS_A_ALT: lhs = a;
      endcase

      // Reserved selectors contribute zero so the result degenerates to LHS + cin.
      rhs     = '0;
      illegal = 1'b0;
      case (rhs_sel)
         RHS_B:     rhs = b;
         RHS_NOT_B: rhs = ~b;
         RHS_ZERO:  rhs = '0;
         RHS_ONES:  rhs = '1;
         RHS_AND:   rhs = a & b;
         RHS_OR:    rhs = a | b;
         RHS_XOR:   rhs = a ^ b;
         RHS_SHR:   rhs = {1'b0, b[DATA_W-1:1]};
         default:   illegal = 1'b1;
      endcase

      cin = 1'b0;
      case (cin_sel)
         CIN_ZERO:  cin = 1'b0;
         CIN_ONE:   cin = 1'b1;
         CIN_C:     cin = carry_flag;
         CIN_NOT_C: cin = ~carry_flag;
      endcase

      sum    = {1'b0, lhs} + {1'b0, rhs} + {{DATA_W{1'b0}}, cin};
      result = sum[DATA_W-1:0];

      flags_next         = '0;
      flags_next[FLAG_C] = sum[DATA_W];
      flags_next[FLAG_Z] = (sum[DATA_W-1:0] == '0);
      flags_next[FLAG_N] = sum[DATA_W-1];
      flags_next[FLAG_V] = (lhs[DATA_W-1] == rhs[DATA_W-1]) && (sum[DATA_W-1] != lhs[DATA_W-1]);
`ifdef ALU_EXEC_PARITY_EN
      flags_next[FLAG_P] = ~^sum[DATA_W-1:0];
`endif
   end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage ALU execute: S1 captures operands/controls, S2 computes and writes result/flags.
// Flags width follows ALU_EXEC_PARITY_EN (see alu_exec_pkg).
module alu_exec_stage
   import alu_exec_pkg::*;
(
   input  logic              Clock,
   input  logic              Reset,
   input  logic              AluActive,
   input  logic              AC0_RHS0,
   input  logic              AC1_RHS1,
   input  logic              AC2_RHS2,
   input  logic              AC3_RHS3,
   input  logic              AC4_LHS0,
   input  logic              AC5_LHS1,
   input  logic              AC6_CS0,
   input  logic              AC7_CS1,
   input  logic [DATA_W-1:0] OpA,
   input  logic [DATA_W-1:0] OpB,
   input  logic              Stall,
   input  logic              FlagLoad,
   input  logic [FLAG_W-1:0] FlagIn,
   output logic [DATA_W-1:0] AluResult,
   output logic              ResultValid,
   output logic [FLAG_W-1:0] Flags,
   output logic              IllegalOp
);

   logic              s1_valid;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;
   logic [3:0]        s1_rhs_sel;
   logic [1:0]        s1_lhs_sel;
   logic [1:0]        s1_cin_sel;

   logic [DATA_W-1:0] core_result;
   logic [FLAG_W-1:0] core_flags;
   logic              core_illegal;

   alu_exec_core u_core (
      .a          (s1_a),
      .b          (s1_b),
      .rhs_sel    (s1_rhs_sel),
      .lhs_sel    (s1_lhs_sel),
      .cin_sel    (s1_cin_sel),
      .carry_flag (Flags[FLAG_C]),
      .result     (core_result),
      .flags_next (core_flags),
      .illegal    (core_illegal)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         s1_valid    <= 1'b0;
         s1_a        <= '0;
         s1_b        <= '0;
         s1_rhs_sel  <= '0;
         s1_lhs_sel  <= '0;
         s1_cin_sel  <= '0;
         AluResult   <= '0;
         ResultValid <= 1'b0;
         Flags       <= '0;
         IllegalOp   <= 1'b0;
      end else begin
         ResultValid <= 1'b0;
         if (!Stall) begin
            s1_valid <= AluActive;
            if (AluActive) begin
               s1_a       <= OpA;
               s1_b       <= OpB;
               s1_rhs_sel <= {AC3_RHS3, AC2_RHS2, AC1_RHS1, AC0_RHS0};
               s1_lhs_sel <= {AC5_LHS1, AC4_LHS0};
               s1_cin_sel <= {AC7_CS1, AC6_CS0};
            end
            if (s1_valid) begin
               AluResult   <= core_result;
               ResultValid <= 1'b1;
               if (core_illegal) IllegalOp <= 1'b1;
            end
         end
         // An explicit flag restore overrides the computed flags, even while stalled.
         if (FlagLoad)
            Flags <= FlagIn;
         else if (!Stall && s1_valid)
            Flags <= core_flags;
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus random ops against a scoreboard.
module tb_alu_exec_stage;
   import alu_exec_pkg::*;

   logic              Clock = 1'b0;
   logic              Reset;
   logic              AluActive;
   logic              AC0_RHS0, AC1_RHS1, AC2_RHS2, AC3_RHS3;
   logic              AC4_LHS0, AC5_LHS1, AC6_CS0, AC7_CS1;
   logic [DATA_W-1:0] OpA, OpB;
   logic              Stall;
   logic              FlagLoad;
   logic [FLAG_W-1:0] FlagIn;
   logic [DATA_W-1:0] AluResult;
   logic              ResultValid;
   logic [FLAG_W-1:0] Flags;
   logic              IllegalOp;

   int          checks = 0;
   int          fails  = 0;
   logic [11:0] exp_q[$];
   logic [11:0] exp_item;
   logic [7:0]  model_result;
   logic [3:0]  model_flags;

   alu_exec_stage dut (
      .Clock(Clock), .Reset(Reset), .AluActive(AluActive),
      .AC0_RHS0(AC0_RHS0), .AC1_RHS1(AC1_RHS1), .AC2_RHS2(AC2_RHS2), .AC3_RHS3(AC3_RHS3),
      .AC4_LHS0(AC4_LHS0), .AC5_LHS1(AC5_LHS1), .AC6_CS0(AC6_CS0), .AC7_CS1(AC7_CS1),
      .OpA(OpA), .OpB(OpB), .Stall(Stall), .FlagLoad(FlagLoad), .FlagIn(FlagIn),
      .AluResult(AluResult), .ResultValid(ResultValid), .Flags(Flags), .IllegalOp(IllegalOp)
   );

   // clock / reset
   always #5 Clock = ~Clock;

   // scoreboard: every ResultValid pulse must match the oldest expected {flags, result}
   always @(negedge Clock) begin
      if (!Reset && ResultValid) begin
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: result %h flags %h, required no ResultValid", AluResult, Flags[3:0]);
         end else begin
            exp_item = exp_q.pop_front();
            if ({Flags[3:0], AluResult} !== exp_item) begin
               fails++;
               $display("FAIL sb_result: got flags %h result %h, required flags %h result %h",
                        Flags[3:0], AluResult, exp_item[11:8], exp_item[7:0]);
            end
         end
      end
   end

   function automatic logic [11:0] model_op(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] rs, input logic [1:0] ls,
                                            input logic [1:0] cs, input logic c_flag);
      int l, r, ci, s, res;
      logic fc, fz, fn, fv;
      l = (ls == 2'd1) ? 0 : (ls == 2'd2) ? (255 - int'(a)) : int'(a);
      case (rs)
         4'd0: r = int'(b);
         4'd1: r = 255 - int'(b);
         4'd2: r = 0;
         4'd3: r = 255;
         4'd4: r = int'(a & b);
         4'd5: r = int'(a | b);
         4'd6: r = int'(a ^ b);
         4'd7: r = int'(b) / 2;
         default: r = 0;
      endcase
      ci = (cs == 2'd0) ? 0 : (cs == 2'd1) ? 1 : (cs == 2'd2) ? int'(c_flag) : int'(!c_flag);
      s   = l + r + ci;
      res = s % 256;
      fc  = (s > 255);
      fz  = (res == 0);
      fn  = (res >= 128);
      fv  = ((l >= 128) == (r >= 128)) && ((res >= 128) != (l >= 128));
      return {fv, fn, fz, fc, 8'(res)};
   endfunction

   // driver tasks
   task automatic step();
      @(negedge Clock);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] res, input logic [3:0] fl);
      exp_q.push_back({fl, res});
      model_result = res;
      model_flags  = fl;
   endtask

   task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] rs,
                           input logic [1:0] ls, input logic [1:0] cs);
      AluActive = 1'b1;
      OpA = a;
      OpB = b;
      {AC3_RHS3, AC2_RHS2, AC1_RHS1, AC0_RHS0} = rs;
      {AC5_LHS1, AC4_LHS0} = ls;
      {AC7_CS1, AC6_CS0} = cs;
      step();
   endtask

   task automatic wait_empty();
      AluActive = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      drive_op(8'hAA, 8'h55, 4'd0, 2'd0, 2'd0);
      FlagLoad = 1'b1;
      FlagIn   = 4'hF;
      step();
      step();
      FlagLoad = 1'b0;
      checks += 4;
      if (AluResult !== 8'h00) begin fails++; $display("FAIL reset_result: got %h, required 00", AluResult); end
      if (Flags[3:0] !== 4'h0) begin fails++; $display("FAIL reset_flags: got %h, required 0", Flags[3:0]); end
      if (ResultValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", ResultValid); end
      if (IllegalOp !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %b, required 0", IllegalOp); end
      AluActive = 1'b0;
      Reset = 1'b0;
      model_result = 8'h00;
      model_flags  = 4'h0;
      step();
      step();
      checks++;
      if (ResultValid !== 1'b0) begin fails++; $display("FAIL reset_release_valid: got %b, required 0", ResultValid); end
   endtask

   task automatic test_add();
      push_exp(8'h80, 4'hC);
      drive_op(8'h7F, 8'h01, 4'd0, 2'd0, 2'd0);
      AluActive = 1'b0;
      checks++;
      if (ResultValid !== 1'b0) begin fails++; $display("FAIL add_early_valid: got %b, required 0", ResultValid); end
      step();
      checks += 3;
      if (ResultValid !== 1'b1) begin fails++; $display("FAIL add_valid: got %b, required 1", ResultValid); end
      if (AluResult !== 8'h80) begin fails++; $display("FAIL add_result: got %h, required 80", AluResult); end
      if (Flags[3:0] !== 4'hC) begin fails++; $display("FAIL add_flags: got %h, required C", Flags[3:0]); end
      step();
      checks++;
      if (ResultValid !== 1'b0) begin fails++; $display("FAIL add_pulse_len: got %b, required 0", ResultValid); end
   endtask

   task automatic test_sub();
      push_exp(8'h00, 4'h3);
      drive_op(8'h05, 8'h05, 4'd1, 2'd0, 2'd1);
      wait_empty();
      checks++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL sub_timeout: %0d pending, required 0", exp_q.size()); end
   endtask

   task automatic test_carry_chain();
      push_exp(8'h00, 4'h3);
      drive_op(8'hFF, 8'h01, 4'd0, 2'd0, 2'd0);
      push_exp(8'h01, 4'h0);
      drive_op(8'h00, 8'h00, 4'd0, 2'd0, 2'd2);
      wait_empty();
      checks += 2;
      if (exp_q.size() != 0) begin fails++; $display("FAIL chain_timeout: %0d pending, required 0", exp_q.size()); end
      if (AluResult !== 8'h01 || Flags[0] !== 1'b0) begin
         fails++;
         $display("FAIL chain_final: got result %h C %b, required 01 C 0", AluResult, Flags[0]);
      end
   endtask

   task automatic test_stall();
      logic [7:0] prev;
      prev = model_result;
      push_exp(8'h33, 4'h0);
      drive_op(8'h21, 8'h12, 4'd0, 2'd0, 2'd0);
      Stall = 1'b1;
      drive_op(8'hFF, 8'hFF, 4'd0, 2'd0, 2'd1);
      step();
      step();
      for (int i = 0; i < 1; i++) begin
         checks += 2;
         if (ResultValid !== 1'b0) begin fails++; $display("FAIL stall_valid: got %b, required 0", ResultValid); end
         if (AluResult !== prev) begin fails++; $display("FAIL stall_hold: got %h, required %h", AluResult, prev); end
      end
      Stall = 1'b0;
      AluActive = 1'b0;
      step();
      checks += 2;
      if (ResultValid !== 1'b1) begin fails++; $display("FAIL stall_release_valid: got %b, required 1", ResultValid); end
      if (AluResult !== 8'h33) begin fails++; $display("FAIL stall_release_result: got %h, required 33", AluResult); end
      step();
      step();
      checks++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL stall_timeout: %0d pending, required 0", exp_q.size()); end
   endtask

   task automatic test_flag_load();
      push_exp(8'h30, 4'hA);
      drive_op(8'h10, 8'h20, 4'd0, 2'd0, 2'd0);
      AluActive = 1'b0;
      FlagLoad  = 1'b1;
      FlagIn    = 4'hA;
      step();
      FlagLoad = 1'b0;
      checks += 2;
      if (Flags[3:0] !== 4'hA) begin fails++; $display("FAIL flagload_flags: got %h, required A", Flags[3:0]); end
      if (AluResult !== 8'h30) begin fails++; $display("FAIL flagload_result: got %h, required 30", AluResult); end
      Stall    = 1'b1;
      FlagLoad = 1'b1;
      FlagIn   = 4'h5;
      step();
      Stall    = 1'b0;
      FlagLoad = 1'b0;
      model_flags = 4'h5;
      checks += 2;
      if (Flags[3:0] !== 4'h5) begin fails++; $display("FAIL flagload_stalled: got %h, required 5", Flags[3:0]); end
      if (AluResult !== 8'h30) begin fails++; $display("FAIL flagload_stall_hold: got %h, required 30", AluResult); end
   endtask

   task automatic test_illegal();
      push_exp(8'h42, 4'h0);
      drive_op(8'h42, 8'h99, 4'd9, 2'd0, 2'd0);
      AluActive = 1'b0;
      checks++;
      if (IllegalOp !== 1'b0) begin fails++; $display("FAIL illegal_early: got %b, required 0", IllegalOp); end
      step();
      checks += 2;
      if (IllegalOp !== 1'b1) begin fails++; $display("FAIL illegal_set: got %b, required 1", IllegalOp); end
      if (AluResult !== 8'h42) begin fails++; $display("FAIL illegal_result: got %h, required 42", AluResult); end
      push_exp(8'h03, 4'h0);
      drive_op(8'h01, 8'h02, 4'd0, 2'd0, 2'd0);
      wait_empty();
      checks++;
      if (IllegalOp !== 1'b1) begin fails++; $display("FAIL illegal_sticky: got %b, required 1", IllegalOp); end
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      model_result = 8'h00;
      model_flags  = 4'h0;
      checks++;
      if (IllegalOp !== 1'b0) begin fails++; $display("FAIL illegal_clear: got %b, required 0", IllegalOp); end
   endtask

   task automatic test_reset_mid_op();
      drive_op(8'h11, 8'h22, 4'd0, 2'd0, 2'd0);
      AluActive = 1'b0;
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (ResultValid !== 1'b0) begin fails++; $display("FAIL reset_drop: cycle %0d got %b, required 0", i, ResultValid); end
      end
      checks++;
      if (AluResult !== 8'h00) begin fails++; $display("FAIL reset_drop_result: got %h, required 00", AluResult); end
   endtask

   task automatic test_back_to_back();
      logic [11:0] e;
      logic [7:0]  a, b;
      logic [3:0]  rs;
      logic [1:0]  ls, cs;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            rs = 4'($urandom_range(0, 7));
            ls = 2'($urandom_range(0, 3));
            cs = 2'($urandom_range(0, 3));
            e  = model_op(a, b, rs, ls, cs, model_flags[0]);
            push_exp(e[7:0], e[11:8]);
            drive_op(a, b, rs, ls, cs);
         end else begin
            AluActive = 1'b0;
            step();
         end
      end
      wait_empty();
      checks++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_timeout: %0d pending, required 0", exp_q.size()); end
   endtask

   initial begin
      Reset = 1'b1;
      AluActive = 1'b0;
      {AC3_RHS3, AC2_RHS2, AC1_RHS1, AC0_RHS0} = 4'd0;
      {AC5_LHS1, AC4_LHS0, AC7_CS1, AC6_CS0} = 4'd0;
      OpA = '0;
      OpB = '0;
      Stall = 1'b0;
      FlagLoad = 1'b0;
      FlagIn = '0;
      model_result = 8'h00;
      model_flags  = 4'h0;
      test_reset();
      test_add();
      test_sub();
      test_carry_chain();
      test_stall();
      test_flag_load();
      test_illegal();
      test_reset_mid_op();
      test_back_to_back();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
